// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing (x/y, syncs, blank, strobes) from a divided system clock.
// Optional macro VGA_FRAME_CNT_EN builds an 8-bit completed-frame counter on frame_cnt.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pix_en,
   output logic       vga_clk,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 1024");
   end
   if (CLK_DIV < 2) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 2");
   end

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          pix_en_q, pix_en_d, vga_clk_q, vga_clk_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic          h_wrap, v_wrap;

   // Every output is derived from the next counter values so it lands on the same edge as x/y.
   always_comb begin
      pix_en_d      = div_q == DW'(CLK_DIV - 1);
      div_d         = pix_en_d ? '0 : div_q + 1'b1;
      h_wrap        = x_q == 10'(H_TOTAL - 1);
      v_wrap        = y_q == 10'(V_TOTAL - 1);
      x_d           = pix_en_d ? (h_wrap ? '0 : x_q + 10'd1) : x_q;
      y_d           = (pix_en_d && h_wrap) ? (v_wrap ? '0 : y_q + 10'd1) : y_q;
      hsync_d       = ((x_d >= 10'(H_ACTIVE + H_FP)) && (x_d < 10'(H_ACTIVE + H_FP + H_SYNC))) ~^ SYNC_POL;
      vsync_d       = ((y_d >= 10'(V_ACTIVE + V_FP)) && (y_d < 10'(V_ACTIVE + V_FP + V_SYNC))) ~^ SYNC_POL;
      blank_n_d     = (x_d < 10'(H_ACTIVE)) && (y_d < 10'(V_ACTIVE));
      vga_clk_d     = div_d >= DW'(CLK_DIV / 2);
      line_start_d  = pix_en_d && h_wrap;
      frame_start_d = line_start_d && v_wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         pix_en_q      <= 1'b0;
         vga_clk_q     <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         blank_n_q     <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_en_q      <= pix_en_d;
         vga_clk_q     <= vga_clk_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_n_q     <= blank_n_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
   always_comb frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end
   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

   assign x           = x_q;
   assign y           = y_q;
   assign pix_en      = pix_en_q;
   assign vga_clk     = vga_clk_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_n_q;
   assign sync_n      = 1'b0;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: compact raster timing checked each clk against a clock-count reference model.
module tb_vga_timing_gen;
   localparam int CD = 3, HA = 8, HF = 2, HS = 3, HB = 2, VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;

   logic clk = 1'b0, rst = 1'b1;
   logic [9:0] x, y;
   logic pix_en, vga_clk, hsync, vsync, blank_n, sync_n, line_start, frame_start;
   logic [7:0] frame_cnt;
   int total = 0, bad = 0;
   int n = 0;

   vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .pix_en(pix_en), .vga_clk(vga_clk),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
      .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s at n=%0d: got=%0d want=%0d", tag, n, obs, exp);
      end
   endtask

   // Reference: n clock edges since release give p = n/CD completed pixels.
   task automatic check_model;
      int p, hc, vc, pe, ls;
      p  = n / CD;
      hc = p % HT;
      vc = (p / HT) % VT;
      pe = (n > 0 && n % CD == 0) ? 1 : 0;
      ls = (pe == 1 && hc == 0) ? 1 : 0;
      chk("x", 32'(x), 32'(hc));
      chk("y", 32'(y), 32'(vc));
      chk("pix_en", 32'(pix_en), 32'(pe));
      chk("vga_clk", 32'(vga_clk), 32'((n % CD) >= CD / 2));
      chk("hsync", 32'(hsync), 32'(!(hc >= HA + HF && hc < HA + HF + HS)));
      chk("vsync", 32'(vsync), 32'(!(vc >= VA + VF && vc < VA + VF + VS)));
      chk("blank_n", 32'(blank_n), 32'(hc < HA && vc < VA));
      chk("sync_n", 32'(sync_n), 32'(0));
      chk("line_start", 32'(line_start), 32'(ls));
      chk("frame_start", 32'(frame_start), 32'(ls == 1 && vc == 0));
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'((p / (HT * VT)) % 256));
`else
      chk("frame_cnt", 32'(frame_cnt), 32'(0));
`endif
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         check_model();
      end
   endtask

   initial begin
      @(negedge clk);
      n = 0;
      check_model();
      @(negedge clk);
      rst = 1'b0;
      check_model();
      run(3 * HT * VT * CD + 7);
      for (int k = 0; k < 6; k++) begin
         run(int'($urandom_range(5, HT * VT * CD)));
         @(posedge clk);
         #2 rst = 1'b1;
         #1 n = 0;
         check_model();
         repeat (int'($urandom_range(1, 3))) @(posedge clk);
         @(negedge clk);
         check_model();
         rst = 1'b0;
      end
      run(2 * HT * VT * CD);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
